// File: rtl/rv32_pkg.sv
// Shared definitions for the rv32_cpu pipeline: the NOP encoding, default
// reset/trap vectors, the fetch FSM state encoding and a word-align helper.
package rv32_pkg;

   // addi x0,x0,0 -- injected whenever the fetch stage has no instruction
   localparam logic [31:0] RV32I_NOP                  = 32'h0000_0013;
   localparam logic [31:0] RV32I_DEFAULT_RESET_VECTOR = 32'h0000_0000;
   localparam logic [31:0] RV32I_TRAP_VECTOR          = 32'h0000_0040;

   typedef enum logic [1:0] {
      FETCH_IDLE = 2'd0,
      FETCH_RUN  = 2'd1,
      FETCH_HELD = 2'd2
   } fetch_state_e;

   function automatic logic [31:0] word_align(input logic [31:0] addr);
      return addr & 32'hFFFF_FFFC;
   endfunction

endpackage

// File: rtl/rv32i_fetch_hold.sv
// One-entry hold (skid) buffer for the fetch stage. Captures an instruction
// returning while the pipeline is stalled and releases it on drain.
// Priority: clear > load > drain.
module rv32i_fetch_hold
   import rv32_pkg::*;
#(
   parameter logic [31:0] RESET_PC = RV32I_DEFAULT_RESET_VECTOR
)
(
   input  logic        clk,
   input  logic        reset,
   input  logic        load,
   input  logic [31:0] load_instr,
   input  logic [31:0] load_pc,
   input  logic        drain,
   input  logic        clear,
   output logic        valid,
   output logic [31:0] instr,
   output logic [31:0] pc
);

   // buffer entry: filled on load, emptied on drain or a redirect clear
   always_ff @(posedge clk) begin
      if (reset) begin
         valid <= 1'b0;
         instr <= RV32I_NOP;
         pc    <= RESET_PC;
      end else if (clear) begin
         valid <= 1'b0;
      end else if (load) begin
         valid <= 1'b1;
         instr <= load_instr;
         pc    <= load_pc;
      end else if (drain) begin
         valid <= 1'b0;
      end
   end

endmodule

// File: rtl/rv32i_fetch.sv
// RV32I instruction fetch stage. Owns the PC, issues word reads over a
// wait-request port and hands instr/pc pairs to the decoder, injecting NOPs
// on bubbles. Optional feature macro: RV32I_FETCH_MISALIGN_TRAP_EN (redirects
// to a misaligned target go to the trap vector and pulse misalign_trap).
//
// Read handshake: a read is accepted on a clock edge where iread is high and
// iwaitrequest is low; once iread is raised it stays high with a stable
// iaddress until accepted, and ireaddata is valid the cycle after acceptance.
module rv32i_fetch
   import rv32_pkg::*;
#(
   parameter logic [31:0] RV32I_RESET_VECTOR = RV32I_DEFAULT_RESET_VECTOR
)
(
   input  logic        clk,
   input  logic        reset,
   output logic [31:0] iaddress,
   output logic        iread,
   input  logic        iwaitrequest,
   input  logic [31:0] ireaddata,
   input  logic        update_pc,
   input  logic [31:0] new_pc,
   input  logic        stall,
   output logic [31:0] instr,
   output logic [31:0] pc,
   output logic        misalign_trap,
   output logic [1:0]  dbg_state
);

   fetch_state_e state_q, state_d;

   logic [31:0] fetch_pc;
   logic        rd_pending;
   logic        rd_kill;
   logic [31:0] rd_pc;
   // a request left waiting across a redirect keeps its old address and is
   // dropped when it finally completes
   logic        req_kill;
   logic [31:0] req_addr;

   logic [31:0] instr_q, pc_q;
   logic        trap_q;

   logic        hb_valid;
   logic [31:0] hb_instr, hb_pc;

   logic        accept, data_valid, hb_load, hb_drain;
   logic        redirect_trap;
   logic [31:0] redirect_pc;

   assign accept     = iread & ~iwaitrequest;
   assign data_valid = rd_pending & ~rd_kill;
   assign hb_load    = ~update_pc & stall & data_valid;
   assign hb_drain   = ~update_pc & ~stall & hb_valid;

   // redirect target selection (misaligned targets trap or get truncated)
   always_comb begin
`ifdef RV32I_FETCH_MISALIGN_TRAP_EN
      redirect_trap = (new_pc[1:0] != 2'b00);
      redirect_pc   = redirect_trap ? RV32I_TRAP_VECTOR : new_pc;
`else
      redirect_trap = 1'b0;
      redirect_pc   = new_pc & 32'hFFFF_FFFC;
`endif
   end

   // FSM state register
   always_ff @(posedge clk) begin
      if (reset) state_q <= FETCH_IDLE;
      else       state_q <= state_d;
   end

   // FSM next state: HELD while the hold buffer owns an instruction
   always_comb begin
      state_d = state_q;
      case (state_q)
         FETCH_IDLE: state_d = FETCH_RUN;
         FETCH_RUN:  if (hb_load) state_d = FETCH_HELD;
         FETCH_HELD: if (update_pc || !stall) state_d = FETCH_RUN;
         default:    state_d = FETCH_IDLE;
      endcase
   end

   // FSM outputs: read request and address
   always_comb begin
      iread     = ~reset & (state_q != FETCH_IDLE) & ~hb_valid & ~(stall & rd_pending);
      iaddress  = req_kill ? req_addr : word_align(fetch_pc);
      dbg_state = state_q;
   end

   // read tracking: fetch PC, in-flight read and stale-request bookkeeping
   always_ff @(posedge clk) begin
      if (reset) begin
         fetch_pc   <= RV32I_RESET_VECTOR;
         rd_pending <= 1'b0;
         rd_kill    <= 1'b0;
         rd_pc      <= RV32I_RESET_VECTOR;
         req_kill   <= 1'b0;
         req_addr   <= RV32I_RESET_VECTOR;
      end else begin
         rd_pending <= accept;
         if (accept) begin
            rd_pc   <= iaddress;
            rd_kill <= update_pc | req_kill;
         end else begin
            rd_kill <= 1'b0;
         end

         if (accept) begin
            req_kill <= 1'b0;
         end else if (update_pc && iread) begin
            req_kill <= 1'b1;
            req_addr <= iaddress;
         end

         if (update_pc)
            fetch_pc <= redirect_pc;
         else if (accept && !req_kill)
            fetch_pc <= word_align(fetch_pc) + 32'd4;
      end
   end

   // decoder-facing registers: redirect > drain buffer > returning read > NOP
   always_ff @(posedge clk) begin
      if (reset) begin
         instr_q <= RV32I_NOP;
         pc_q    <= RV32I_RESET_VECTOR;
         trap_q  <= 1'b0;
      end else begin
         trap_q <= update_pc & redirect_trap;
         if (update_pc) begin
            instr_q <= RV32I_NOP;
         end else if (!stall) begin
            if (hb_valid) begin
               instr_q <= hb_instr;
               pc_q    <= hb_pc;
            end else if (data_valid) begin
               instr_q <= ireaddata;
               pc_q    <= rd_pc;
            end else begin
               instr_q <= RV32I_NOP;
            end
         end
      end
   end

   assign instr         = instr_q;
   assign pc            = pc_q;
   assign misalign_trap = trap_q;

   rv32i_fetch_hold #(
      .RESET_PC (RV32I_RESET_VECTOR)
   ) u_hold (
      .clk        (clk),
      .reset      (reset),
      .load       (hb_load),
      .load_instr (ireaddata),
      .load_pc    (rd_pc),
      .drain      (hb_drain),
      .clear      (update_pc),
      .valid      (hb_valid),
      .instr      (hb_instr),
      .pc         (hb_pc)
   );

endmodule
